// File: rtl/apple1_board_ctrl.sv
// Board-level control for the apple1 core: button synchronise/debounce, core reset
// sequencing, clear-screen level, long-press palette cycling and monochrome colour mapping.
module apple1_board_ctrl #(
    parameter int NUM_BUTTONS       = 2,
    parameter int BTN_ACTIVE_LOW    = 0,
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int POR_CYCLES        = 1024,
    parameter int RST_STRETCH       = 4096,
    parameter int LONG_PRESS_CYCLES = 25000000,
    parameter int RESET_BTN         = 0,
    parameter int CLS_BTN           = 1,
    parameter int PALETTE_DEFAULT   = 0
) (
    input  logic                   clk25,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] button,
    input  logic                   vga_bit,
    output logic                   sys_rst_n,
    output logic                   cls,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [1:0]             palette,
    output logic [3:0]             vga_r,
    output logic [3:0]             vga_g,
    output logic [3:0]             vga_b,
    output logic [1:0]             led
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RST_MAX = (POR_CYCLES > RST_STRETCH) ? POR_CYCLES : RST_STRETCH;
    localparam int RC_W    = $clog2(RST_MAX + 1);
    localparam int LP_W    = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [1:0] PAL_INIT =
        (PALETTE_DEFAULT > 2 || PALETTE_DEFAULT < 0) ? 2'd0 : 2'(PALETTE_DEFAULT);

    typedef enum logic [1:0] {
        ST_POR,
        ST_RUN,
        ST_HOLD,
        ST_STRETCH
    } rst_state_e;

    logic [NUM_BUTTONS-1:0] btn_fixed;
    logic [NUM_BUTTONS-1:0] sync1_q, sync1_d;
    logic [NUM_BUTTONS-1:0] sync2_q, sync2_d;
    logic [NUM_BUTTONS-1:0] stable_q, stable_d;
    logic [NUM_BUTTONS-1:0] press_q, press_d;
    logic [DB_W-1:0]        db_cnt_q [NUM_BUTTONS];
    logic [DB_W-1:0]        db_cnt_d [NUM_BUTTONS];

    rst_state_e             state_q, state_d;
    logic [RC_W-1:0]        rc_q, rc_d;
    logic                   sys_rst_n_q, sys_rst_n_d;

    logic [LP_W-1:0]        lp_q, lp_d;
    logic [1:0]             pal_q, pal_d;
    logic                   cls_int;

    // After the polarity fix every button reads 1 when pressed.
    assign btn_fixed = (BTN_ACTIVE_LOW != 0) ? ~button : button;

    always_comb begin
        sync1_d  = btn_fixed;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
        press_d = stable_d & ~stable_q;
    end

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        unique case (state_q)
            ST_POR: begin
                if (rc_q == RC_W'(POR_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    rc_d    = '0;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            ST_RUN: begin
                rc_d = '0;
                if (stable_q[RESET_BTN]) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                rc_d = '0;
                if (!stable_q[RESET_BTN]) begin
                    state_d = ST_STRETCH;
                end
            end
            ST_STRETCH: begin
                if (stable_q[RESET_BTN]) begin
                    state_d = ST_HOLD;
                    rc_d    = '0;
                end else if (rc_q == RC_W'(RST_STRETCH - 1)) begin
                    state_d = ST_RUN;
                    rc_d    = '0;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            default: begin
                state_d = ST_POR;
                rc_d    = '0;
            end
        endcase
        sys_rst_n_d = (state_d == ST_RUN);
    end

    // A reset press that debounces together with clear must never show cls for the
    // single cycle before sys_rst_n drops, so the reset level gates cls directly.
    assign cls_int = stable_q[CLS_BTN] & sys_rst_n_q & ~stable_q[RESET_BTN];

    always_comb begin
        lp_d  = lp_q;
        pal_d = pal_q;
        if (!cls_int) begin
            lp_d = '0;
        end else if (lp_q != LP_W'(LONG_PRESS_CYCLES)) begin
            lp_d = lp_q + LP_W'(1);
            if (lp_q == LP_W'(LONG_PRESS_CYCLES - 1)) begin
                pal_d = (pal_q >= 2'd2) ? 2'd0 : pal_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            press_q     <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                db_cnt_q[i] <= '0;
            end
            state_q     <= ST_POR;
            rc_q        <= '0;
            sys_rst_n_q <= 1'b0;
            lp_q        <= '0;
            pal_q       <= PAL_INIT;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stable_q    <= stable_d;
            press_q     <= press_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q     <= state_d;
            rc_q        <= rc_d;
            sys_rst_n_q <= sys_rst_n_d;
            lp_q        <= lp_d;
            pal_q       <= pal_d;
        end
    end

    // Colour stays combinational so pixels remain aligned with the core's syncs.
    always_comb begin
        vga_r = 4'h0;
        vga_g = 4'h0;
        vga_b = 4'h0;
        if (vga_bit) begin
            unique case (pal_q)
                2'd1: begin
                    vga_r = 4'hF;
                    vga_g = 4'hB;
                    vga_b = 4'h0;
                end
                2'd2: begin
                    vga_r = 4'hF;
                    vga_g = 4'hF;
                    vga_b = 4'hF;
                end
                default: begin
                    vga_r = 4'h8;
                    vga_g = 4'hF;
                    vga_b = 4'h8;
                end
            endcase
        end
    end

    assign sys_rst_n = sys_rst_n_q;
    assign cls       = cls_int;
    assign btn_level = stable_q;
    assign btn_press = press_q;
    assign palette   = pal_q;
    assign led       = {~cls_int, sys_rst_n_q};

endmodule

// File: tb/tb_apple1_board_ctrl.sv
// Table-driven bench for apple1_board_ctrl: an active-high and an active-low instance
// receive the same logical stimulus and must both match the hand-computed vectors.
module tb_apple1_board_ctrl;

    logic        clk25 = 1'b0;
    logic        rst;
    logic [1:0]  button_hi;
    logic [1:0]  button_lo;
    logic        vga_bit;

    logic        sys_rst_n_hi, cls_hi, sys_rst_n_lo, cls_lo;
    logic [1:0]  btn_level_hi, btn_press_hi, palette_hi, led_hi;
    logic [1:0]  btn_level_lo, btn_press_lo, palette_lo, led_lo;
    logic [3:0]  vga_r_hi, vga_g_hi, vga_b_hi, vga_r_lo, vga_g_lo, vga_b_lo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  btn;
        logic        vga;
        int          cycles;
        logic        exp_rst_n;
        logic        exp_cls;
        logic [1:0]  exp_level;
        logic [1:0]  exp_press;
        logic [1:0]  exp_pal;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vecs[$];

    always #5 clk25 = ~clk25;

    apple1_board_ctrl #(
        .NUM_BUTTONS(2), .BTN_ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4), .POR_CYCLES(8),
        .RST_STRETCH(4), .LONG_PRESS_CYCLES(16), .RESET_BTN(0), .CLS_BTN(1),
        .PALETTE_DEFAULT(0)
    ) dut_hi (
        .clk25(clk25), .rst(rst), .button(button_hi), .vga_bit(vga_bit),
        .sys_rst_n(sys_rst_n_hi), .cls(cls_hi), .btn_level(btn_level_hi),
        .btn_press(btn_press_hi), .palette(palette_hi), .vga_r(vga_r_hi),
        .vga_g(vga_g_hi), .vga_b(vga_b_hi), .led(led_hi)
    );

    apple1_board_ctrl #(
        .NUM_BUTTONS(2), .BTN_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .POR_CYCLES(8),
        .RST_STRETCH(4), .LONG_PRESS_CYCLES(16), .RESET_BTN(0), .CLS_BTN(1),
        .PALETTE_DEFAULT(0)
    ) dut_lo (
        .clk25(clk25), .rst(rst), .button(button_lo), .vga_bit(vga_bit),
        .sys_rst_n(sys_rst_n_lo), .cls(cls_lo), .btn_level(btn_level_lo),
        .btn_press(btn_press_lo), .palette(palette_lo), .vga_r(vga_r_lo),
        .vga_g(vga_g_lo), .vga_b(vga_b_lo), .led(led_lo)
    );

    task automatic addVec(input logic r, input logic [1:0] b, input logic v, input int n,
                          input logic e_rn, input logic e_cls, input logic [1:0] e_lvl,
                          input logic [1:0] e_prs, input logic [1:0] e_pal,
                          input logic [11:0] e_rgb);
        vec_t t;
        t.rst = r; t.btn = b; t.vga = v; t.cycles = n;
        t.exp_rst_n = e_rn; t.exp_cls = e_cls; t.exp_level = e_lvl;
        t.exp_press = e_prs; t.exp_pal = e_pal; t.exp_rgb = e_rgb;
        vecs.push_back(t);
    endtask

    // The active-low instance sees the electrically inverted pins.
    task automatic applyStimulus(input logic r, input logic [1:0] b, input logic v);
        rst       = r;
        button_hi = b;
        button_lo = ~b;
        vga_bit   = v;
    endtask

    task automatic checkOutput(input string name, input logic [21:0] actual,
                               input logic [21:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [21:0] packHi();
        return {sys_rst_n_hi, cls_hi, btn_level_hi, btn_press_hi, palette_hi,
                vga_r_hi, vga_g_hi, vga_b_hi, led_hi};
    endfunction

    function automatic logic [21:0] packLo();
        return {sys_rst_n_lo, cls_lo, btn_level_lo, btn_press_lo, palette_lo,
                vga_r_lo, vga_g_lo, vga_b_lo, led_lo};
    endfunction

    function automatic logic [21:0] packExp(input vec_t t);
        return {t.exp_rst_n, t.exp_cls, t.exp_level, t.exp_press, t.exp_pal,
                t.exp_rgb, ~t.exp_cls, t.exp_rst_n};
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int press_cnt_hi;
        int press_cnt_lo;
        int cls_cnt;
        int busy_cnt;

        applyStimulus(1'b1, 2'b00, 1'b0);

        //      rst btn  vga cyc | rst_n cls lvl   prs   pal  rgb
        // reset state, then power-on reset of 8 cycles
        addVec(1, 2'b00, 0, 1,    0, 0, 2'b00, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b00, 1, 7,    0, 0, 2'b00, 2'b00, 2'd0, 12'h8F8);
        addVec(0, 2'b00, 1, 1,    1, 0, 2'b00, 2'b00, 2'd0, 12'h8F8);
        addVec(0, 2'b00, 0, 1,    1, 0, 2'b00, 2'b00, 2'd0, 12'h000);
        // 3-cycle glitch is rejected; 6-cycle press is accepted at cycle 6
        addVec(0, 2'b01, 0, 3,    1, 0, 2'b00, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b00, 0, 5,    1, 0, 2'b00, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b01, 0, 5,    1, 0, 2'b00, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b01, 0, 1,    1, 0, 2'b01, 2'b01, 2'd0, 12'h000);
        addVec(0, 2'b00, 0, 1,    0, 0, 2'b01, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b00, 0, 4,    0, 0, 2'b01, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b00, 0, 1,    0, 0, 2'b00, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b00, 0, 4,    0, 0, 2'b00, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b00, 0, 1,    1, 0, 2'b00, 2'b00, 2'd0, 12'h000);
        // reset button held 20 cycles, released, re-pressed inside STRETCH
        addVec(0, 2'b01, 0, 6,    1, 0, 2'b01, 2'b01, 2'd0, 12'h000);
        addVec(0, 2'b01, 0, 1,    0, 0, 2'b01, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b01, 0, 13,   0, 0, 2'b01, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b00, 0, 4,    0, 0, 2'b01, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b01, 0, 2,    0, 0, 2'b00, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b01, 0, 4,    0, 0, 2'b01, 2'b01, 2'd0, 12'h000);
        addVec(0, 2'b01, 0, 1,    0, 0, 2'b01, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b01, 0, 5,    0, 0, 2'b01, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b00, 0, 6,    0, 0, 2'b00, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b00, 0, 4,    0, 0, 2'b00, 2'b00, 2'd0, 12'h000);
        addVec(0, 2'b00, 0, 1,    1, 0, 2'b00, 2'b00, 2'd0, 12'h000);
        // long presses of clear: 0->1 at hold 16, no repeat, then 1->2->0->1
        addVec(0, 2'b10, 1, 6,    1, 1, 2'b10, 2'b10, 2'd0, 12'h8F8);
        addVec(0, 2'b10, 1, 15,   1, 1, 2'b10, 2'b00, 2'd0, 12'h8F8);
        addVec(0, 2'b10, 1, 1,    1, 1, 2'b10, 2'b00, 2'd1, 12'hFB0);
        addVec(0, 2'b10, 1, 14,   1, 1, 2'b10, 2'b00, 2'd1, 12'hFB0);
        addVec(0, 2'b00, 1, 6,    1, 0, 2'b00, 2'b00, 2'd1, 12'hFB0);
        addVec(0, 2'b10, 1, 21,   1, 1, 2'b10, 2'b00, 2'd1, 12'hFB0);
        addVec(0, 2'b10, 1, 1,    1, 1, 2'b10, 2'b00, 2'd2, 12'hFFF);
        addVec(0, 2'b00, 1, 6,    1, 0, 2'b00, 2'b00, 2'd2, 12'hFFF);
        addVec(0, 2'b10, 1, 21,   1, 1, 2'b10, 2'b00, 2'd2, 12'hFFF);
        addVec(0, 2'b10, 1, 1,    1, 1, 2'b10, 2'b00, 2'd0, 12'h8F8);
        addVec(0, 2'b00, 1, 6,    1, 0, 2'b00, 2'b00, 2'd0, 12'h8F8);
        addVec(0, 2'b10, 1, 22,   1, 1, 2'b10, 2'b00, 2'd1, 12'hFB0);
        addVec(0, 2'b00, 1, 6,    1, 0, 2'b00, 2'b00, 2'd1, 12'hFB0);
        // reset and clear together: reset wins; then rst mid-STRETCH restarts POR
        addVec(0, 2'b11, 1, 6,    1, 0, 2'b11, 2'b11, 2'd1, 12'hFB0);
        addVec(0, 2'b11, 1, 20,   0, 0, 2'b11, 2'b00, 2'd1, 12'hFB0);
        addVec(0, 2'b00, 1, 6,    0, 0, 2'b00, 2'b00, 2'd1, 12'hFB0);
        addVec(0, 2'b00, 1, 2,    0, 0, 2'b00, 2'b00, 2'd1, 12'hFB0);
        addVec(1, 2'b00, 1, 1,    0, 0, 2'b00, 2'b00, 2'd0, 12'h8F8);
        addVec(0, 2'b00, 1, 7,    0, 0, 2'b00, 2'b00, 2'd0, 12'h8F8);
        addVec(0, 2'b00, 1, 1,    1, 0, 2'b00, 2'b00, 2'd0, 12'h8F8);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].btn, vecs[i].vga);
            repeat (vecs[i].cycles) @(posedge clk25);
            #1;
            checkOutput($sformatf("vec%0d active-high", i), packHi(), packExp(vecs[i]));
            checkOutput($sformatf("vec%0d active-low", i), packLo(), packExp(vecs[i]));
        end

        // Glitch on the clear button must never reach level or press on any cycle.
        busy_cnt = 0;
        applyStimulus(1'b0, 2'b10, 1'b0);
        for (int c = 0; c < 12; c++) begin
            if (c == 3) applyStimulus(1'b0, 2'b00, 1'b0);
            @(posedge clk25);
            #1;
            if (btn_level_hi != 2'b00 || btn_press_hi != 2'b00 ||
                btn_level_lo != 2'b00 || btn_press_lo != 2'b00) busy_cnt++;
        end
        checkCount("glitch cycles with activity", busy_cnt, 0);

        // Short clear press: exactly one press pulse, cls from cycle 6 on, no palette step.
        press_cnt_hi = 0;
        press_cnt_lo = 0;
        cls_cnt      = 0;
        applyStimulus(1'b0, 2'b10, 1'b1);
        for (int c = 0; c < 14; c++) begin
            @(posedge clk25);
            #1;
            if (btn_press_hi[1]) press_cnt_hi++;
            if (btn_press_lo[1]) press_cnt_lo++;
            if (cls_hi) cls_cnt++;
        end
        checkCount("press pulses active-high", press_cnt_hi, 1);
        checkCount("press pulses active-low", press_cnt_lo, 1);
        checkCount("cls high cycles", cls_cnt, 9);
        applyStimulus(1'b0, 2'b00, 1'b1);
        repeat (8) @(posedge clk25);
        #1;
        checkCount("palette after short press", int'(palette_hi), 0);
        checkCount("cls after release", int'(cls_hi), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
